// File: rtl/dport_train_if.sv
// dport_train_if: AUX-channel request/acknowledge bundle between the link-training
// sequencer (master) and the AUX transaction engine (slave).
interface dport_train_if;
  logic       aux_req;
  logic [1:0] aux_op;
  logic       aux_ack;
  logic       aux_err;
  logic [7:0] aux_rdata;

  modport master (output aux_req, aux_op, input aux_ack, aux_err, aux_rdata);
  modport slave  (input aux_req, aux_op, output aux_ack, aux_err, aux_rdata);
endinterface

// File: rtl/dport_train.sv
// dport_train: two-lane DisplayPort link-training sequencer (TPS1 clock recovery, TPS2 EQ).
// Optional DPORT_LINKMON_EN: periodic lane-status poll in ACTIVE, retraining on loss.
module dport_train #(
  parameter int TRAIN_WAIT = 8100,
  parameter int MAX_TRIES  = 5,
  parameter int MON_CYC    = 65535
) (
  input  logic          dpclk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  dport_train_if.master aux,
  output logic [1:0]    phymode,
  output logic          busy,
  output logic          linkup,
  output logic          fail
);
  typedef enum logic [3:0] {
    S_IDLE, S_CR_SET, S_CR_WAIT, S_CR_READ, S_EQ_SET, S_EQ_WAIT, S_EQ_READ,
    S_END_SET, S_ACTIVE, S_FAIL, S_MON_READ
  } state_t;

  localparam logic [15:0] WAIT_LOAD = 16'(TRAIN_WAIT - 1);
  localparam logic [15:0] MON_LOAD  = 16'(MON_CYC - 1);
  localparam logic [2:0]  TRY_MAX   = 3'(MAX_TRIES);
  localparam logic [7:0]  CR_MASK   = 8'h11;
  localparam logic [7:0]  EQ_MASK   = 8'h77;

  state_t      state, state_nxt;
  logic [2:0]  tries, tries_nxt, tries_inc;
  logic [15:0] tmr;
  logic        stop_lat, ack, stop_eff, cr_ok, eq_ok;
  logic        req_nxt, busy_nxt, issue_nxt;
  logic [1:0]  op_nxt, mode_nxt;

  // acks that arrive with no request outstanding are dropped here
  assign ack       = aux.aux_ack & aux.aux_req;
  assign stop_eff  = stop | stop_lat;
  assign cr_ok     = (aux.aux_rdata & CR_MASK) == CR_MASK;
  assign eq_ok     = (aux.aux_rdata & EQ_MASK) == EQ_MASK;
  assign tries_inc = (tries >= TRY_MAX) ? TRY_MAX : tries + 3'd1;

  always_comb begin
    state_nxt = state;
    tries_nxt = tries;
    if (aux.aux_req) begin
      // a transaction in flight only ends on its ack; a pending stop is taken then
      if (ack) begin
        if (stop_eff) begin
          state_nxt = S_IDLE;
        end else begin
          case (state)
            S_CR_SET: begin
              if (aux.aux_err) tries_nxt = tries_inc;
              state_nxt = S_CR_WAIT;
            end
            S_EQ_SET: begin
              if (aux.aux_err) tries_nxt = tries_inc;
              state_nxt = S_EQ_WAIT;
            end
            S_CR_READ: begin
              if (!aux.aux_err && cr_ok) begin
                state_nxt = S_EQ_SET;
                tries_nxt = '0;
              end else begin
                tries_nxt = tries_inc;
                state_nxt = (tries_inc == TRY_MAX) ? S_FAIL : S_CR_WAIT;
              end
            end
            S_EQ_READ: begin
              if (!aux.aux_err && eq_ok) begin
                state_nxt = S_END_SET;
              end else if (!aux.aux_err && !cr_ok) begin
                state_nxt = S_FAIL;
              end else begin
                tries_nxt = tries_inc;
                state_nxt = (tries_inc == TRY_MAX) ? S_FAIL : S_EQ_WAIT;
              end
            end
            S_END_SET: state_nxt = S_ACTIVE;
`ifdef DPORT_LINKMON_EN
            S_MON_READ: begin
              if (aux.aux_err || !eq_ok) begin
                state_nxt = S_CR_SET;
                tries_nxt = '0;
              end else begin
                state_nxt = S_ACTIVE;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end else if (stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FAIL: begin
          if (start) begin
            state_nxt = S_CR_SET;
            tries_nxt = '0;
          end
        end
        S_ACTIVE: begin
          if (start) begin
            state_nxt = S_CR_SET;
            tries_nxt = '0;
          end
`ifdef DPORT_LINKMON_EN
          else if (tmr == '0) begin
            state_nxt = S_MON_READ;
          end
`endif
        end
        S_CR_WAIT: if (tmr == '0) state_nxt = S_CR_READ;
        S_EQ_WAIT: if (tmr == '0) state_nxt = S_EQ_READ;
        default: ;
      endcase
    end
  end

  // output decode from the next state so registered outputs move with the state
  always_comb begin
    op_nxt    = 2'd0;
    mode_nxt  = 2'd0;
    issue_nxt = 1'b0;
    busy_nxt  = 1'b0;
    case (state_nxt)
      S_CR_SET:   begin op_nxt = 2'd1; mode_nxt = 2'd2; issue_nxt = 1'b1; busy_nxt = 1'b1; end
      S_CR_WAIT:  begin mode_nxt = 2'd2; busy_nxt = 1'b1; end
      S_CR_READ:  begin mode_nxt = 2'd2; issue_nxt = 1'b1; busy_nxt = 1'b1; end
      S_EQ_SET:   begin op_nxt = 2'd2; mode_nxt = 2'd3; issue_nxt = 1'b1; busy_nxt = 1'b1; end
      S_EQ_WAIT:  begin mode_nxt = 2'd3; busy_nxt = 1'b1; end
      S_EQ_READ:  begin mode_nxt = 2'd3; issue_nxt = 1'b1; busy_nxt = 1'b1; end
      S_END_SET:  begin op_nxt = 2'd3; mode_nxt = 2'd3; issue_nxt = 1'b1; busy_nxt = 1'b1; end
      S_ACTIVE:   mode_nxt = 2'd1;
      S_MON_READ: begin mode_nxt = 2'd1; issue_nxt = 1'b1; end
      default: ;
    endcase
    // request rises one cycle after entry and drops on the ack edge
    req_nxt = issue_nxt && (state_nxt == state);
  end

  always_ff @(posedge dpclk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tries       <= '0;
      tmr         <= '0;
      stop_lat    <= 1'b0;
      aux.aux_req <= 1'b0;
      aux.aux_op  <= 2'd0;
      phymode     <= 2'd0;
      busy        <= 1'b0;
      linkup      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state    <= state_nxt;
      tries    <= tries_nxt;
      stop_lat <= aux.aux_req & ~ack & (stop_lat | stop);
      if (state_nxt != state && (state_nxt == S_CR_WAIT || state_nxt == S_EQ_WAIT))
        tmr <= WAIT_LOAD;
      else if (state_nxt != state && state_nxt == S_ACTIVE)
        tmr <= MON_LOAD;
      else if (tmr != '0)
        tmr <= tmr - 16'd1;
      aux.aux_req <= req_nxt;
      aux.aux_op  <= op_nxt;
      phymode     <= mode_nxt;
      busy        <= busy_nxt;
      linkup      <= (state_nxt == S_ACTIVE) || (state_nxt == S_MON_READ);
      fail        <= (state_nxt == S_FAIL);
    end
  end
endmodule
